// File: rtl/count_pkg.sv
// count_pkg: shared widths and FSM state encoding for the count_monitor slice.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package count_pkg;

  localparam int COUNT_W  = 2;   // upstream counter width
  localparam int ONEHOT_W = 4;   // 1 << COUNT_W

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,   // waiting for a first sample to anchor prev
    ST_TRACK  = 2'd1,   // counting consecutive correct increments
    ST_LOCKED = 2'd2    // sequence confirmed, breaks are errors
  } state_t;

endpackage

// File: rtl/count_onehot_dec.sv
// count_onehot_dec: combinational 2-to-4 one-hot decode of a counter value.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports:
//   value  - binary counter value (COUNT_W bits)
//   onehot - 1 << value (ONEHOT_W bits)
module count_onehot_dec
  import count_pkg::*;
(
  input  logic [COUNT_W-1:0]  value,
  output logic [ONEHOT_W-1:0] onehot
);

  always_comb begin
    onehot        = '0;
    onehot[value] = 1'b1;
  end

endmodule

// File: rtl/count_monitor.sv
// count_monitor: checks that a 2-bit up counter steps by +1 mod 4, locks after LOCK_N good steps, flags breaks.
// Latency: all outputs registered, valid one cycle after the en sample; locked follows the state register.
// Backpressure: none; a sample is consumed on every cycle with en high.
//
// Ports:
//   clk        - single clock, all state changes on posedge
//   reset      - asynchronous active-low reset
//   en         - count_in carries a valid sample this cycle
//   count_in   - sample from the upstream counter
//   clr_err    - synchronous clear of err_sticky / err_cnt
//   onehot_out - registered 1 << count_in of the last valid sample
//   wrap_pulse - one-cycle pulse after a 3->0 step seen while locked
//   locked     - FSM is in LOCKED
//   err_sticky - a sequence break happened while locked
//   err_cnt    - saturating count of breaks while locked
//
// Build option: define COUNT_MONITOR_ERRCNT_EN to build the err_cnt counter;
// without it err_cnt is a constant 0 and only err_sticky records breaks.
module count_monitor
  import count_pkg::*;
#(
  parameter int LOCK_N = 2,   // 1..15 consecutive good steps to lock
  parameter int ERR_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [COUNT_W-1:0]  count_in,
  input  logic                clr_err,
  output logic [ONEHOT_W-1:0] onehot_out,
  output logic                wrap_pulse,
  output logic                locked,
  output logic                err_sticky,
  output logic [ERR_W-1:0]    err_cnt
);

  state_t              state_q;
  logic [COUNT_W-1:0]  prev_q;
  logic [COUNT_W-1:0]  prev_inc;
  logic [3:0]          match_cnt_q;
  logic [3:0]          match_inc;
  logic [ONEHOT_W-1:0] onehot_dec;
  logic                step_ok;
  logic                brk_locked;
  logic                wrap_hit;

  // prev_inc is COUNT_W wide, so 3 + 1 wraps to 0 and counts as a good step.
  // A repeated value never equals prev + 1, so it is a mismatch.
  assign prev_inc   = prev_q + COUNT_W'(1);
  assign step_ok    = (count_in == prev_inc);
  assign match_inc  = match_cnt_q + 4'd1;
  assign brk_locked = en && (state_q == ST_LOCKED) && !step_ok;
  assign wrap_hit   = en && (state_q == ST_LOCKED) &&
                      (prev_q == {COUNT_W{1'b1}}) && (count_in == '0);

  assign locked = (state_q == ST_LOCKED);

  count_onehot_dec u_dec (
    .value  (count_in),
    .onehot (onehot_dec)
  );

  // Sequence FSM. prev follows every valid sample in every state, good or bad.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_SEARCH;
      prev_q      <= '0;
      match_cnt_q <= '0;
    end else if (en) begin
      prev_q <= count_in;
      case (state_q)
        ST_SEARCH: begin
          match_cnt_q <= '0;
          state_q     <= ST_TRACK;
        end
        ST_TRACK: begin
          if (step_ok) begin
            match_cnt_q <= match_inc;
            if (match_inc == 4'(LOCK_N)) begin
              state_q <= ST_LOCKED;
            end
          end else begin
            match_cnt_q <= '0;
          end
        end
        ST_LOCKED: begin
          if (!step_ok) begin
            match_cnt_q <= '0;
            state_q     <= ST_TRACK;
          end
        end
        default: begin
          match_cnt_q <= '0;
          state_q     <= ST_SEARCH;
        end
      endcase
    end
  end

  // Output registers. A break in the same cycle as clr_err wins for the
  // sticky flag, so the new error is never lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      onehot_out <= '0;
      wrap_pulse <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      wrap_pulse <= wrap_hit;
      if (en) begin
        onehot_out <= onehot_dec;
      end
      if (brk_locked) begin
        err_sticky <= 1'b1;
      end else if (clr_err) begin
        err_sticky <= 1'b0;
      end
    end
  end

`ifdef COUNT_MONITOR_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt_q;

  // Saturating counter; a break coinciding with clr_err restarts at 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt_q <= '0;
    end else if (brk_locked) begin
      if (clr_err) begin
        err_cnt_q <= ERR_W'(1);
      end else if (err_cnt_q != {ERR_W{1'b1}}) begin
        err_cnt_q <= err_cnt_q + ERR_W'(1);
      end
    end else if (clr_err) begin
      err_cnt_q <= '0;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor: directed vectors for count_monitor with a cycle-tagged expectation queue.
// Latency: each vector is checked on the falling edge after the rising edge that samples it.
// Backpressure: n/a.
module tb_count_monitor;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] count_in;
  logic       clr_err;
  logic [3:0] onehot_out;
  logic       wrap_pulse;
  logic       locked;
  logic       err_sticky;
  logic [1:0] err_cnt;

`ifdef COUNT_MONITOR_ERRCNT_EN
  localparam bit ERRCNT_ON = 1'b1;
`else
  localparam bit ERRCNT_ON = 1'b0;
`endif

  count_monitor #(.LOCK_N(2), .ERR_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .count_in   (count_in),
    .clr_err    (clr_err),
    .onehot_out (onehot_out),
    .wrap_pulse (wrap_pulse),
    .locked     (locked),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         id;
    logic [3:0] oh;
    logic       wr;
    logic       lk;
    logic       st;
    logic [1:0] cn;
  } exp_t;

  exp_t sbq[$];
  exp_t mx;
  int   cyc    = 0;
  int   vec_id = 0;
  int   n_vec  = 0;
  int   n_err  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop the expectation whose target cycle has come and compare.
  always @(negedge clk) begin
    if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
      mx = sbq.pop_front();
      n_vec++;
      if (mx.cyc != cyc || onehot_out !== mx.oh || wrap_pulse !== mx.wr ||
          locked !== mx.lk || err_sticky !== mx.st || err_cnt !== mx.cn) begin
        n_err++;
        $display("FAIL vec%0d @cyc%0d: got oh=%b wrap=%b lock=%b sticky=%b cnt=%0d, want oh=%b wrap=%b lock=%b sticky=%b cnt=%0d",
                 mx.id, cyc, onehot_out, wrap_pulse, locked, err_sticky, err_cnt,
                 mx.oh, mx.wr, mx.lk, mx.st, mx.cn);
      end
    end
  end

  // Drive one cycle of stimulus and queue the hand-computed response.
  // cn is the err_cnt value with the counter built; it reads 0 otherwise.
  task automatic v(input logic e, input logic [1:0] c, input logic cl,
                   input logic [3:0] oh, input logic wr, input logic lk,
                   input logic st, input logic [1:0] cn);
    exp_t x;
    @(negedge clk);
    en       = e;
    count_in = c;
    clr_err  = cl;
    vec_id++;
    x.cyc = cyc + 1;
    x.id  = vec_id;
    x.oh  = oh;
    x.wr  = wr;
    x.lk  = lk;
    x.st  = st;
    x.cn  = ERRCNT_ON ? cn : 2'd0;
    sbq.push_back(x);
  endtask

  task automatic chk_rst(input string name);
    n_vec++;
    if (onehot_out !== 4'b0000 || wrap_pulse !== 1'b0 || locked !== 1'b0 ||
        err_sticky !== 1'b0 || err_cnt !== 2'd0) begin
      n_err++;
      $display("FAIL %s: got oh=%b wrap=%b lock=%b sticky=%b cnt=%0d, want all zero",
               name, onehot_out, wrap_pulse, locked, err_sticky, err_cnt);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    en       = 1'b0;
    count_in = 2'd0;
    clr_err  = 1'b0;
    #3;
    chk_rst("rst_init");
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    //  en cin clr  onehot  wr lk st cnt
    // lock and wrap: 0,1,2,3,0
    v(1, 2'd0, 0, 4'b0001, 0, 0, 0, 2'd0);
    v(1, 2'd1, 0, 4'b0010, 0, 0, 0, 2'd0);
    v(1, 2'd2, 0, 4'b0100, 0, 1, 0, 2'd0);
    v(1, 2'd3, 0, 4'b1000, 0, 1, 0, 2'd0);
    v(1, 2'd0, 0, 4'b0001, 1, 1, 0, 2'd0);
    v(0, 2'd0, 0, 4'b0001, 0, 1, 0, 2'd0);
    // break while locked (1 then 3), relock with 0,1
    v(1, 2'd1, 0, 4'b0010, 0, 1, 0, 2'd0);
    v(1, 2'd3, 0, 4'b1000, 0, 0, 1, 2'd1);
    v(1, 2'd0, 0, 4'b0001, 0, 0, 1, 2'd1);
    v(1, 2'd1, 0, 4'b0010, 0, 1, 1, 2'd1);
    // idle hold: sample 2, five idle cycles with noise on count_in, then 3
    v(1, 2'd2, 0, 4'b0100, 0, 1, 1, 2'd1);
    v(0, 2'd0, 0, 4'b0100, 0, 1, 1, 2'd1);
    v(0, 2'd3, 0, 4'b0100, 0, 1, 1, 2'd1);
    v(0, 2'd1, 0, 4'b0100, 0, 1, 1, 2'd1);
    v(0, 2'd2, 0, 4'b0100, 0, 1, 1, 2'd1);
    v(0, 2'd0, 0, 4'b0100, 0, 1, 1, 2'd1);
    v(1, 2'd3, 0, 4'b1000, 0, 1, 1, 2'd1);
    // plain clear while idle keeps the lock
    v(0, 2'd0, 1, 4'b1000, 0, 1, 0, 2'd0);
    // three breaks to reach err_cnt=3 (incl. repeated value, TRACK 3->0 no wrap)
    v(1, 2'd1, 0, 4'b0010, 0, 0, 1, 2'd1);
    v(1, 2'd2, 0, 4'b0100, 0, 0, 1, 2'd1);
    v(1, 2'd3, 0, 4'b1000, 0, 1, 1, 2'd1);
    v(1, 2'd3, 0, 4'b1000, 0, 0, 1, 2'd2);
    v(1, 2'd0, 0, 4'b0001, 0, 0, 1, 2'd2);
    v(1, 2'd1, 0, 4'b0010, 0, 1, 1, 2'd2);
    v(1, 2'd0, 0, 4'b0001, 0, 0, 1, 2'd3);
    v(1, 2'd1, 0, 4'b0010, 0, 0, 1, 2'd3);
    v(1, 2'd2, 0, 4'b0100, 0, 1, 1, 2'd3);
    // clear colliding with a locked break
    v(1, 2'd0, 1, 4'b0001, 0, 0, 1, 2'd1);
    // clear while tracking, relock, then five breaks to saturate at 3
    v(1, 2'd1, 1, 4'b0010, 0, 0, 0, 2'd0);
    v(1, 2'd2, 0, 4'b0100, 0, 1, 0, 2'd0);
    v(1, 2'd2, 0, 4'b0100, 0, 0, 1, 2'd1);
    v(1, 2'd3, 0, 4'b1000, 0, 0, 1, 2'd1);
    v(1, 2'd0, 0, 4'b0001, 0, 1, 1, 2'd1);
    v(1, 2'd0, 0, 4'b0001, 0, 0, 1, 2'd2);
    v(1, 2'd1, 0, 4'b0010, 0, 0, 1, 2'd2);
    v(1, 2'd2, 0, 4'b0100, 0, 1, 1, 2'd2);
    v(1, 2'd2, 0, 4'b0100, 0, 0, 1, 2'd3);
    v(1, 2'd3, 0, 4'b1000, 0, 0, 1, 2'd3);
    v(1, 2'd0, 0, 4'b0001, 0, 1, 1, 2'd3);
    v(1, 2'd0, 0, 4'b0001, 0, 0, 1, 2'd3);
    v(1, 2'd1, 0, 4'b0010, 0, 0, 1, 2'd3);
    v(1, 2'd2, 0, 4'b0100, 0, 1, 1, 2'd3);
    v(1, 2'd2, 0, 4'b0100, 0, 0, 1, 2'd3);
    v(1, 2'd3, 0, 4'b1000, 0, 0, 1, 2'd3);
    v(1, 2'd0, 0, 4'b0001, 0, 1, 1, 2'd3);
    v(1, 2'd1, 0, 4'b0010, 0, 1, 1, 2'd3);

    // async reset between edges while locked
    @(negedge clk);
    #2 reset = 1'b0;
    en = 1'b0;
    #1 chk_rst("rst_async");
    en       = 1'b1;
    count_in = 2'd3;
    @(posedge clk);
    #1 chk_rst("rst_edge");
    en = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;

    // first sample after release anchors SEARCH; lock, then a locked wrap
    v(1, 2'd2, 0, 4'b0100, 0, 0, 0, 2'd0);
    v(1, 2'd3, 0, 4'b1000, 0, 0, 0, 2'd0);
    v(1, 2'd0, 0, 4'b0001, 0, 1, 0, 2'd0);
    v(1, 2'd1, 0, 4'b0010, 0, 1, 0, 2'd0);
    v(1, 2'd2, 0, 4'b0100, 0, 1, 0, 2'd0);
    v(1, 2'd3, 0, 4'b1000, 0, 1, 0, 2'd0);
    v(1, 2'd0, 0, 4'b0001, 1, 1, 0, 2'd0);
    v(0, 2'd2, 0, 4'b0001, 0, 1, 0, 2'd0);

    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter LOCK_N, default 2: consecutive correct increments required to declare lock, range 1..15.
REQ-002 Parameter ERR_W, default 8: width of the error counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset; low clears all state immediately, independent of clk.
REQ-005 en  input  1  count_in is a valid sample this cycle.
REQ-006 count_in  input  2  count value from the upstream 2-bit up counter.
REQ-007 clr_err  input  1  synchronous clear of error status.
REQ-008 onehot_out  output  4  registered one-hot decode of the last valid sample.
REQ-009 wrap_pulse  output  1  one-cycle pulse on a locked 3->0 wrap.
REQ-010 locked  output  1  high while the FSM is in LOCKED.
REQ-011 err_sticky  output  1  set on any sequence break while locked.
REQ-012 err_cnt  output  ERR_W  saturating count of sequence breaks while locked.

Function
REQ-013 FSM states SHALL be SEARCH, TRACK and LOCKED, with SEARCH as the reset state.
REQ-014 SEARCH: on en, store count_in as prev, clear match_cnt and go to TRACK; without en, hold.
REQ-015 TRACK: on en with count_in == (prev+1) mod 4, increment match_cnt; on reaching LOCK_N, go to LOCKED.
REQ-016 TRACK: on en with a mismatch, clear match_cnt and stay in TRACK.
REQ-017 LOCKED: on en with a mismatch, set err_sticky, increment err_cnt and go to TRACK with match_cnt = 0.
REQ-018 prev SHALL update on every en in TRACK and LOCKED, whether the sample matches or not.
REQ-019 Increment check SHALL use 2-bit modular arithmetic, so 3->0 counts as a correct step.
REQ-020 Repeated value (count_in == prev) SHALL count as a mismatch.
REQ-021 onehot_out SHALL be 1 << count_in registered one cycle after en and held while en is low.
REQ-022 wrap_pulse SHALL be high for exactly one cycle after an en sample in LOCKED where prev == 3 and count_in == 0.
REQ-023 wrap_pulse SHALL never fire in SEARCH or TRACK.
REQ-024 err_cnt SHALL saturate at 2^ERR_W-1 and never roll over.
REQ-025 clr_err SHALL clear err_sticky and err_cnt on the next edge without affecting FSM state.
REQ-026 If clr_err coincides with a locked mismatch, the result SHALL be err_sticky = 1 and err_cnt = 1.
REQ-027 Cycles with en low SHALL change no state other than clearing wrap_pulse and applying clr_err.

Reset
REQ-028 While reset is low, outputs SHALL read: onehot_out = 4'b0000, wrap_pulse = 0, locked = 0, err_sticky = 0, err_cnt = 0.
REQ-029 While reset is low, internal state SHALL be: FSM = SEARCH, prev = 0, match_cnt = 0.
REQ-030 Reset asserted mid-operation SHALL abort tracking; after release, monitoring restarts in SEARCH.
REQ-031 The first posedge after reset release SHALL be processed normally.

Configuration
REQ-032 Macro COUNT_MONITOR_ERRCNT_EN defined: the err_cnt register and its saturation logic are built as specified.
REQ-033 Macro COUNT_MONITOR_ERRCNT_EN absent: err_cnt is tied to 0, no counter register exists, and err_sticky behaves unchanged.

Structure
REQ-034 Package count_pkg SHALL hold the FSM state enum, COUNT_W = 2, and the ONEHOT_W = 4 constant.
REQ-035 Sub-module count_onehot_dec SHALL implement the combinational 2-to-4 one-hot decode; all registers stay in count_monitor.

Verification
REQ-036 Lock and wrap: reset, then en=1 with samples 0,1,2,3,0 -> locked=1 after the 3rd sample (LOCK_N=2); wrap_pulse for one cycle after sample 0; err_sticky=0.
REQ-037 Break while locked: locked, then samples 1,3 -> err_sticky=1, err_cnt=1, locked=0; samples 0,1 -> relocked.
REQ-038 Idle hold: locked at sample 2, en low for 5 cycles, then sample 3 -> locked stays 1; onehot_out holds 4'b0100, then 4'b1000.
REQ-039 Clear collision: err_cnt=3, clr_err pulsed together with a locked mismatch -> err_cnt=1, err_sticky=1.
REQ-040 Saturation, ERR_W=2: 5 locked breaks -> err_cnt=3; without COUNT_MONITOR_ERRCNT_EN -> err_cnt=0 and err_sticky=1.
REQ-041 Async reset mid-lock: reset low between edges -> all outputs 0 immediately; after release, first sample is treated as SEARCH.
